// File: rtl/pwm_pkg.sv
// Shared PWM constants, sample type and the saturating offset-removal helper.
// Optional build macro for the demodulator: PWM_DEMOD_GLITCH_FILTER_EN.
package pwm_pkg;

    localparam int unsigned DATA_WIDTH    = 12;
    localparam int unsigned COUNTER_WIDTH = 10;
    localparam int unsigned OFFSET        = 512;
    localparam int unsigned FRAME_LEN     = 1 << COUNTER_WIDTH;

    localparam int SAT_MIN = -int'(OFFSET);
    localparam int SAT_MAX = int'(FRAME_LEN) - 1 - int'(OFFSET);

    typedef logic signed [DATA_WIDTH-1:0] sample_t;

    // The generator is high for v+1 cycles, hence the extra -1.
    function automatic sample_t sat_sample(input logic [COUNTER_WIDTH:0] h);
        logic signed [DATA_WIDTH:0] diff;
        diff = $signed({{(DATA_WIDTH - COUNTER_WIDTH){1'b0}}, h})
             - $signed((DATA_WIDTH + 1)'(OFFSET + 1));
        if (diff < $signed((DATA_WIDTH + 1)'(SAT_MIN))) begin
            return sample_t'(SAT_MIN);
        end
        if (diff > $signed((DATA_WIDTH + 1)'(SAT_MAX))) begin
            return sample_t'(SAT_MAX);
        end
        return sample_t'(diff);
    endfunction

endpackage

// File: rtl/pwm_demod_if.sv
// PWM demodulator bus: incoming bitstream plus recovered sample stream.
interface pwm_demod_if;
    import pwm_pkg::*;

    logic    PWMIn;
    sample_t DataOut;
    logic    DataValid;
    logic    NoSignal;

    modport master (
        input  PWMIn,
        output DataOut,
        output DataValid,
        output NoSignal
    );

    modport slave (
        output PWMIn,
        input  DataOut,
        input  DataValid,
        input  NoSignal
    );

endinterface

// File: rtl/pwm_in_sync.sv
// Two-flop synchronizer for PWMIn, optional 3-sample majority filter
// (PWM_DEMOD_GLITCH_FILTER_EN) and an edge strobe on the cleaned level.
module pwm_in_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_i,
    output logic s_o,
    output logic edge_o
);

    logic sync1_q, sync2_q, s_prev_q;
    logic s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pwm_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef PWM_DEMOD_GLITCH_FILTER_EN
    logic hist1_q, hist2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
        end else begin
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
        end
    end

    // A level must persist for two samples before it wins the vote.
    assign s = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
`else
    assign s = sync2_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_prev_q <= 1'b0;
        end else begin
            s_prev_q <= s;
        end
    end

    assign s_o    = s;
    assign edge_o = s ^ s_prev_q;

endmodule

// File: rtl/pwm_demod.sv
// PWM demodulator: counts high cycles over 2^COUNTER_WIDTH-clock frames and emits a
// saturated signed sample per frame. Build option: PWM_DEMOD_GLITCH_FILTER_EN.
module pwm_demod
    import pwm_pkg::*;
(
    input logic        clk,
    input logic        rst_n,
    pwm_demod_if.master bus
);

    logic s;
    logic edge_pulse;

    pwm_in_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_i  (bus.PWMIn),
        .s_o    (s),
        .edge_o (edge_pulse)
    );

    logic [COUNTER_WIDTH-1:0] fc_q, fc_d;
    logic [COUNTER_WIDTH:0]   acc_q, acc_d;
    logic [COUNTER_WIDTH:0]   h;
    logic                     edge_seen_q, edge_seen_d;
    sample_t                  data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     nosig_q, nosig_d;
    logic                     frame_end;

    always_comb begin
        frame_end   = (fc_q == COUNTER_WIDTH'(FRAME_LEN - 1));
        h           = acc_q + {{COUNTER_WIDTH{1'b0}}, s};
        fc_d        = fc_q + COUNTER_WIDTH'(1);
        acc_d       = h;
        edge_seen_d = edge_seen_q | edge_pulse;
        valid_d     = frame_end;
        data_d      = data_q;
        nosig_d     = nosig_q;
        // h already holds the final sample; the next frame starts from zero.
        if (frame_end) begin
            acc_d       = '0;
            edge_seen_d = 1'b0;
            data_d      = sat_sample(h);
            nosig_d     = ~(edge_seen_q | edge_pulse);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fc_q        <= '0;
            acc_q       <= '0;
            edge_seen_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            nosig_q     <= 1'b0;
        end else begin
            fc_q        <= fc_d;
            acc_q       <= acc_d;
            edge_seen_q <= edge_seen_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            nosig_q     <= nosig_d;
        end
    end

    assign bus.DataOut   = data_q;
    assign bus.DataValid = valid_q;
    assign bus.NoSignal  = nosig_q;

endmodule
